// File: rtl/att_dot_engine.sv
// att_dot_engine: attention dot-product execution unit.
// Accumulates a signed INT8 dot product one 32-bit word pair per instruction.
// The final word applies an optional Q8.8 scale/shift and clamp, and every
// accepted instruction returns exactly one result beat.
module att_dot_engine #(
  parameter int ID_WIDTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [3:0]          issue_opcode_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [4:0]          issue_rd_i,
  input  logic [31:0]         rs1_i,
  input  logic [31:0]         rs2_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o,
  output logic                result_err_o,
  output logic [31:0]         result_data_o,
  output logic                busy_o
);

  localparam logic [3:0] OP_SETUP = 4'b1000;
  localparam logic [3:0] OP_RUN   = 4'b1001;
  localparam logic [3:0] OP_SCALE = 4'b1010;

  typedef enum logic [1:0] {IDLE, MAC, POST, RESP} state_t;
  state_t state, state_next;

  logic [3:0]          op_reg;
  logic [31:0]         a_reg, b_reg;
  logic                cfg_valid;
  logic [6:0]          k_words, word_idx;
  logic [3:0]          shift;
  logic signed [15:0]  scale;
  logic signed [31:0]  acc;

  logic accept, in_setup, in_run, word_final;
  logic [6:0] word_idx_inc;
  logic signed [15:0] lane_prod [4];
  logic signed [17:0] dot4;
  logic signed [31:0] acc_sum, y_val;
  logic signed [47:0] prod, shifted;
  logic signed [31:0] sat_val;

  assign accept       = issue_valid_i && (state == IDLE);
  assign in_setup     = (issue_opcode_i == OP_SETUP);
  assign in_run       = (issue_opcode_i[3:2] == 2'b10) && !in_setup;
  assign word_idx_inc = word_idx + 7'd1;
  assign word_final   = (word_idx_inc == k_words);

  // Signed 8x8 product for each of the four byte lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_prod[gi] = $signed(a_reg[8*gi+7 -: 8]) * $signed(b_reg[8*gi+7 -: 8]);
    end
  endgenerate

  assign dot4 = $signed({{2{lane_prod[0][15]}}, lane_prod[0]})
              + $signed({{2{lane_prod[1][15]}}, lane_prod[1]})
              + $signed({{2{lane_prod[2][15]}}, lane_prod[2]})
              + $signed({{2{lane_prod[3][15]}}, lane_prod[3]});
  assign acc_sum = acc + $signed({{14{dot4[17]}}, dot4});

  // Post-op: Q8.8 scale, arithmetic shift, saturate, optional 16-bit clamp.
  assign prod    = $signed({{16{acc[31]}}, acc}) * $signed({{32{scale[15]}}, scale});
  assign shifted = prod >>> (5'd8 + {1'b0, shift});

  // Saturate the shifted product to 32 bits and pick the final-op result.
  always_comb begin
    sat_val = shifted[31:0];
    if (shifted > 48'sd2147483647)
      sat_val = 32'sh7FFF_FFFF;
    else if (shifted < -48'sd2147483648)
      sat_val = 32'sh8000_0000;
    y_val = sat_val;
    if (op_reg == OP_RUN)
      y_val = acc;
    else if (op_reg != OP_SCALE) begin
      if (sat_val > 32'sd32767)
        y_val = 32'sd32767;
      else if (sat_val < -32'sd32768)
        y_val = -32'sd32768;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (issue_valid_i) state_next = (in_run && cfg_valid) ? MAC : RESP;
      MAC:  state_next = word_final ? POST : RESP;
      POST: state_next = RESP;
      RESP: if (result_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, configuration, accumulator and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_reg        <= 4'd0;
      a_reg         <= 32'd0;
      b_reg         <= 32'd0;
      cfg_valid     <= 1'b0;
      k_words       <= 7'd0;
      word_idx      <= 7'd0;
      shift         <= 4'd0;
      scale         <= 16'sd0;
      acc           <= 32'sd0;
      result_id_o   <= '0;
      result_rd_o   <= 5'd0;
      result_we_o   <= 1'b0;
      result_err_o  <= 1'b0;
      result_data_o <= 32'd0;
    end else begin
      if (accept) begin
        op_reg        <= issue_opcode_i;
        a_reg         <= rs1_i;
        b_reg         <= rs2_i;
        result_id_o   <= issue_id_i;
        result_rd_o   <= issue_rd_i;
        result_we_o   <= 1'b0;
        result_data_o <= 32'd0;
        result_err_o  <= !(in_setup || (in_run && cfg_valid));
        if (in_setup) begin
          k_words   <= (rs1_i[7:0] == 8'd0) ? 7'd64 : {1'b0, rs1_i[7:2]};
          shift     <= rs1_i[11:8];
          scale     <= rs2_i[15:0];
          cfg_valid <= 1'b1;
          acc       <= 32'sd0;
          word_idx  <= 7'd0;
        end
      end
      if (state == MAC) begin
        acc      <= acc_sum;
        word_idx <= word_idx_inc;
      end
      if (state == POST) begin
        result_we_o   <= 1'b1;
        result_data_o <= y_val;
        acc           <= 32'sd0;
        word_idx      <= 7'd0;
      end
    end
  end

  assign issue_ready_o  = (state == IDLE);
  assign result_valid_o = (state == RESP);
  assign busy_o         = (word_idx != 7'd0);

endmodule

// File: tb/tb_att_dot_engine.sv
// Directed testbench for att_dot_engine with hand-computed expectations.
module tb_att_dot_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [3:0]  issue_opcode = 4'd0;
  logic [3:0]  issue_id = 4'd0;
  logic [4:0]  issue_rd = 5'd0;
  logic [31:0] rs1 = 32'd0, rs2 = 32'd0;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [3:0]  result_id;
  logic [4:0]  result_rd;
  logic        result_we, result_err;
  logic [31:0] result_data;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  // Captured beat from the last instruction.
  int          b_lat;
  logic        b_we, b_err, b_busy;
  logic [31:0] b_data;
  logic [3:0]  b_id;
  logic [4:0]  b_rd;

  att_dot_engine #(.ID_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_opcode_i(issue_opcode), .issue_id_i(issue_id), .issue_rd_i(issue_rd),
    .rs1_i(rs1), .rs2_i(rs2),
    .result_valid_o(result_valid), .result_ready_i(result_ready),
    .result_id_o(result_id), .result_rd_o(result_rd),
    .result_we_o(result_we), .result_err_o(result_err),
    .result_data_o(result_data), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Issue one instruction (called #1 after an edge in IDLE), capture its beat,
  // let it retire with result_ready held high.
  task automatic do_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] id, input logic [4:0] rd);
    issue_opcode = op; rs1 = a; rs2 = b; issue_id = id; issue_rd = rd;
    issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    b_lat = 1;
    while (!result_valid && b_lat < 10) begin
      @(posedge clk); #1;
      b_lat++;
    end
    b_we = result_we; b_err = result_err; b_data = result_data;
    b_id = result_id; b_rd = result_rd; b_busy = busy;
    $display("instr op=%b rs1=%h rs2=%h -> lat=%0d we=%b err=%b data=%h busy=%b",
             op, a, b, b_lat, b_we, b_err, b_data, b_busy);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", issue_ready); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", result_valid); end
    n_checks++; if ({result_we, result_err, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {result_we, result_err, busy}); end
    n_checks++; if (result_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", result_data); end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reject();
    do_instr(4'b1001, 32'h01020304, 32'h01010101, 4'd1, 5'd3);
    n_checks++; if (b_lat !== 1 || b_err !== 1'b1 || b_we !== 1'b0) begin n_fail++; $display("FAIL reject_nocfg got lat=%0d err=%b we=%b want 1 1 0", b_lat, b_err, b_we); end
    do_instr(4'b0101, 32'h0, 32'h0, 4'd2, 5'd4);
    n_checks++; if (b_lat !== 1 || b_err !== 1'b1 || b_we !== 1'b0 || b_data !== 32'd0) begin n_fail++; $display("FAIL reject_badop got lat=%0d err=%b we=%b data=%h want 1 1 0 0", b_lat, b_err, b_we, b_data); end
  endtask

  task automatic test_basic();
    do_instr(4'b1000, 32'h004, 32'h0100, 4'd5, 5'd7);
    n_checks++; if (b_lat !== 1 || b_err !== 1'b0 || b_we !== 1'b0) begin n_fail++; $display("FAIL setup_beat got lat=%0d err=%b we=%b want 1 0 0", b_lat, b_err, b_we); end
    do_instr(4'b1001, 32'h01020304, 32'h01010101, 4'd9, 5'd17);
    n_checks++; if (b_lat !== 3 || b_we !== 1'b1 || b_err !== 1'b0) begin n_fail++; $display("FAIL run_beat got lat=%0d we=%b err=%b want 3 1 0", b_lat, b_we, b_err); end
    n_checks++; if (b_data !== 32'd10) begin n_fail++; $display("FAIL run_data got %h want 0000000a", b_data); end
    n_checks++; if (b_id !== 4'd9 || b_rd !== 5'd17) begin n_fail++; $display("FAIL run_tag got id=%0d rd=%0d want 9 17", b_id, b_rd); end
  endtask

  task automatic test_clip();
    do_instr(4'b1000, 32'h008, 32'h0100, 4'd1, 5'd1);
    do_instr(4'b1011, 32'h7F7F7F7F, 32'h81818181, 4'd2, 5'd2);
    n_checks++; if (b_lat !== 2 || b_we !== 1'b0 || b_data !== 32'd0 || b_busy !== 1'b1) begin n_fail++; $display("FAIL clip_partial got lat=%0d we=%b data=%h busy=%b want 2 0 0 1", b_lat, b_we, b_data, b_busy); end
    do_instr(4'b1011, 32'h7F7F7F7F, 32'h81818181, 4'd3, 5'd3);
    n_checks++; if (b_lat !== 3 || b_we !== 1'b1 || b_data !== 32'hFFFF8000 || b_busy !== 1'b0) begin n_fail++; $display("FAIL clip_final got lat=%0d we=%b data=%h busy=%b want 3 1 ffff8000 0", b_lat, b_we, b_data, b_busy); end
  endtask

  task automatic test_scale();
    do_instr(4'b1000, 32'h108, 32'h0080, 4'd4, 5'd4);
    do_instr(4'b1010, 32'h7F7F7F7F, 32'h81818181, 4'd5, 5'd5);
    do_instr(4'b1010, 32'h7F7F7F7F, 32'h81818181, 4'd6, 5'd6);
    n_checks++; if (b_we !== 1'b1 || b_data !== 32'hFFFF81FE) begin n_fail++; $display("FAIL scale_final got we=%b data=%h want 1 ffff81fe", b_we, b_data); end
    do_instr(4'b1001, 32'h7F7F7F7F, 32'h81818181, 4'd7, 5'd7);
    do_instr(4'b1001, 32'h7F7F7F7F, 32'h81818181, 4'd8, 5'd8);
    n_checks++; if (b_we !== 1'b1 || b_data !== 32'hFFFE07F8) begin n_fail++; $display("FAIL plain_run got we=%b data=%h want 1 fffe07f8", b_we, b_data); end
  endtask

  task automatic test_backpressure();
    result_ready = 1'b0;
    issue_opcode = 4'b1000; rs1 = 32'h004; rs2 = 32'h0100; issue_id = 4'd11; issue_rd = 5'd21;
    issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (result_valid !== 1'b1 || issue_ready !== 1'b0 || result_id !== 4'd11 || result_rd !== 5'd21 ||
          result_we !== 1'b0 || result_err !== 1'b0 || result_data !== 32'd0) begin
        n_fail++;
        $display("FAIL bp_hold cycle=%0d got valid=%b ready=%b id=%0d rd=%0d we=%b err=%b data=%h want 1 0 11 21 0 0 0",
                 i, result_valid, issue_ready, result_id, result_rd, result_we, result_err, result_data);
      end
      $display("bp cycle %0d valid=%b ready=%b", i, result_valid, issue_ready);
      @(posedge clk); #1;
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (issue_ready !== 1'b1 || result_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got ready=%b valid=%b want 1 0", issue_ready, result_valid); end
    // Partial accumulation discarded by a new SETUP.
    do_instr(4'b1000, 32'h008, 32'h0100, 4'd1, 5'd1);
    do_instr(4'b1001, 32'h01020304, 32'h01010101, 4'd2, 5'd2);
    do_instr(4'b1000, 32'h004, 32'h0100, 4'd3, 5'd3);
    n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL discard_busy got %b want 0", b_busy); end
    do_instr(4'b1001, 32'h02020202, 32'h03030303, 4'd4, 5'd4);
    n_checks++; if (b_lat !== 3 || b_data !== 32'd24) begin n_fail++; $display("FAIL discard_data got lat=%0d data=%h want 3 00000018", b_lat, b_data); end
  endtask

  task automatic test_reset_mid();
    do_instr(4'b1000, 32'h008, 32'h0100, 4'd1, 5'd1);
    do_instr(4'b1001, 32'h01020304, 32'h01010101, 4'd2, 5'd2);
    issue_opcode = 4'b1001; rs1 = 32'h01020304; rs2 = 32'h01010101; issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || issue_ready !== 1'b0) begin n_fail++; $display("FAIL mid_mac_pre got busy=%b ready=%b want 1 0", busy, issue_ready); end
    #2; rst = 1'b1; #1;
    n_checks++; if (issue_ready !== 1'b1 || result_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL async_reset got ready=%b valid=%b busy=%b want 1 0 0", issue_ready, result_valid, busy); end
    $display("async reset mid-MAC ready=%b valid=%b busy=%b", issue_ready, result_valid, busy);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    do_instr(4'b1001, 32'h01020304, 32'h01010101, 4'd3, 5'd3);
    n_checks++; if (b_err !== 1'b1 || b_we !== 1'b0 || b_lat !== 1) begin n_fail++; $display("FAIL post_reset_run got err=%b we=%b lat=%0d want 1 0 1", b_err, b_we, b_lat); end
  endtask

  initial begin
    test_reset();
    test_reject();
    test_basic();
    test_clip();
    test_scale();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
